// File: rtl/tq_dequant_ctrl.sv
// tq_dequant_ctrl: gathers a 4x4 level block, derives qp/6 and qp%6, captures the dequantiser result and streams rows out.
// Latency: row 3 accepted at edge T -> first output row valid at T+floor(QP/6)+2 (T+2 on a TQ_DQ_QP_CACHE_EN hit).
// Backpressure: input ready only in IDLE/LOAD; output row/index/last hold while out_ready_i is low.
module tq_dequant_ctrl #(
    parameter int COEF_W = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  in_sop_i,
    input  logic [5:0]            qp_i,
    input  logic [4*COEF_W-1:0]   in_row_i,
    output logic [2:0]            dq_qpmod6_o,
    output logic [3:0]            dq_qpdiv6_o,
    output logic [16*COEF_W-1:0]  dq_scale_o,
    input  logic [16*COEF_W-1:0]  dq_coeff_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [4*COEF_W-1:0]   out_row_o,
    output logic [1:0]            out_idx_o,
    output logic                  out_last_o
);
    localparam int         ROW_W  = 4 * COEF_W;
    localparam int         BLK_W  = 16 * COEF_W;
    localparam logic [5:0] QP_MAX = 6'd51;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIVMOD = 3'd2,
        S_CAPT   = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [5:0]         qp_q, qp_d;
    logic [5:0]         rem_q, rem_d;
    logic [3:0]         div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLK_W-1:0]   scale_q, scale_d;
    logic [BLK_W-1:0]   outbuf_q, outbuf_d;

    logic [5:0]         qp_clamped;
    logic               in_fire;
    logic               out_fire;
    logic               cache_hit;
    logic               wr_en;
    logic [1:0]         wr_row;

`ifdef TQ_DQ_QP_CACHE_EN
    logic [5:0]         cqp_q, cqp_d;
    logic               cvld_q, cvld_d;

    assign cache_hit = cvld_q && (cqp_q == qp_q);
`else
    assign cache_hit = 1'b0;
`endif

    assign qp_clamped = (qp_i > QP_MAX) ? QP_MAX : qp_i;
    assign in_fire    = in_valid_i & in_ready_q;
    assign out_fire   = (state_q == S_OUT) & out_ready_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qp_d     = qp_q;
        rem_d    = rem_q;
        div_d    = div_q;
        idx_d    = idx_q;
        outbuf_d = outbuf_q;
        wr_en    = 1'b0;
        wr_row   = cnt_q;
`ifdef TQ_DQ_QP_CACHE_EN
        cqp_d    = cqp_q;
        cvld_d   = cvld_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Rows arriving without sop are accepted and dropped.
                if (in_fire && in_sop_i) begin
                    wr_en   = 1'b1;
                    wr_row  = 2'd0;
                    qp_d    = qp_clamped;
                    cnt_d   = 2'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (in_sop_i) begin
                        wr_row = 2'd0;
                        qp_d   = qp_clamped;
                        cnt_d  = 2'd1;
                    end else begin
                        wr_row = cnt_q;
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = S_DIVMOD;
                            // On a hit rem/div already hold the reduced values, so DIVMOD exits at once.
                            if (!cache_hit) begin
                                rem_d = qp_q;
                                div_d = 4'd0;
`ifdef TQ_DQ_QP_CACHE_EN
                                cqp_d  = qp_q;
                                cvld_d = 1'b1;
`endif
                            end
                        end
                    end
                end
            end
            S_DIVMOD: begin
                if (rem_q >= 6'd6) begin
                    rem_d = rem_q - 6'd6;
                    div_d = div_q + 4'd1;
                end else begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                outbuf_d = dq_coeff_i;
                idx_d    = 2'd0;
                state_d  = S_OUT;
            end
            S_OUT: begin
                if (out_fire) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        scale_d = scale_q;
        for (int r = 0; r < 4; r++) begin
            if (wr_en && (wr_row == 2'(r))) begin
                scale_d[r*ROW_W +: ROW_W] = in_row_i;
            end
        end
    end

    assign in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            cnt_q      <= 2'd0;
            qp_q       <= 6'd0;
            rem_q      <= 6'd0;
            div_q      <= 4'd0;
            idx_q      <= 2'd0;
            scale_q    <= '0;
            outbuf_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            qp_q       <= qp_d;
            rem_q      <= rem_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            scale_q    <= scale_d;
            outbuf_q   <= outbuf_d;
        end
    end

`ifdef TQ_DQ_QP_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cqp_q  <= 6'd0;
            cvld_q <= 1'b0;
        end else begin
            cqp_q  <= cqp_d;
            cvld_q <= cvld_d;
        end
    end
`endif

    always_comb begin
        out_row_o = '0;
        if (state_q == S_OUT) begin
            case (idx_q)
                2'd0:    out_row_o = outbuf_q[0*ROW_W +: ROW_W];
                2'd1:    out_row_o = outbuf_q[1*ROW_W +: ROW_W];
                2'd2:    out_row_o = outbuf_q[2*ROW_W +: ROW_W];
                default: out_row_o = outbuf_q[3*ROW_W +: ROW_W];
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == S_OUT);
    assign out_idx_o   = idx_q;
    assign out_last_o  = (state_q == S_OUT) && (idx_q == 2'd3);
    assign dq_qpmod6_o = rem_q[2:0];
    assign dq_qpdiv6_o = div_q;
    assign dq_scale_o  = scale_q;

endmodule
